// File: rtl/handshake_pkg.sv
// Shared definitions for the round-robin control-channel arbiter:
// buffer depth, buffer occupancy states and the index-width helper.
package handshake_pkg;

    // Depth of the elastic buffer between arbitration and downstream.
    localparam int BUF_SLOTS = 2;

    // Occupancy of the elastic buffer; encoded value equals the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Width of a requester index: max(1, ceil(log2(num_req))).
    function automatic int calc_idx_width(input int num_req);
        int w;
        w = 1;
        while ((1 << w) < num_req) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/handshake_ctrl_rr_arbiter_if.sv
// Requester/grant bundle of the round-robin arbiter. The slave modport is
// the arbiter side; the master modport is the surrounding environment.
interface handshake_ctrl_rr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 grant_valid;
    logic                 grant_ready;
    logic [IDX_WIDTH-1:0] grant_idx;

    modport master (
        output req_valid,
        output grant_ready,
        input  req_ready,
        input  grant_valid,
        input  grant_idx
    );

    modport slave (
        input  req_valid,
        input  grant_ready,
        output req_ready,
        output grant_valid,
        output grant_idx
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: scans requesters starting at
// rr_ptr_i upward with wrap-around and selects the first valid one.
module rr_priority_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [IDX_WIDTH-1:0] rr_ptr_i,
    input  logic                 enable_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [IDX_WIDTH-1:0] winner_idx_o,
    output logic                 any_grant_o
);
    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int SUM_W = IDX_WIDTH + 1;

    logic [IDX_WIDTH-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_valid;

    // Candidate k is requester (rr_ptr + k) mod NUM_REQ; explicit wrap keeps
    // non-power-of-two requester counts correct.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            assign sum = {1'b0, rr_ptr_i} + SUM_W'(gi);
            assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ))
                                ? IDX_WIDTH'(sum - SUM_W'(NUM_REQ))
                                : sum[IDX_WIDTH-1:0];
            assign cand_valid[gi] = req_valid_i[cand_idx[gi]];
        end
    endgenerate

    // Pick the first valid candidate in rotated order and one-hot encode it.
    always_comb begin
        grant_o      = '0;
        winner_idx_o = '0;
        any_grant_o  = 1'b0;
        if (enable_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!any_grant_o && cand_valid[k]) begin
                    any_grant_o  = 1'b1;
                    winner_idx_o = cand_idx[k];
                end
            end
        end
        if (any_grant_o) begin
            grant_o[winner_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/handshake_ctrl_rr_arbiter.sv
// Round-robin arbiter sharing one constant-source control channel among
// NUM_REQ requesters. Winner indices are queued in a 2-slot elastic buffer
// so req_ready never depends combinationally on grant_ready.
module handshake_ctrl_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input logic                          clk,
    input logic                          rst,      // synchronous, active low
    handshake_ctrl_rr_arbiter_if.slave   arb_if
);

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
            $error("handshake_ctrl_rr_arbiter: NUM_REQ must be in 1..16");
        end
        if (IDX_WIDTH != calc_idx_width(NUM_REQ)) begin : g_bad_idx_width
            $error("handshake_ctrl_rr_arbiter: IDX_WIDTH does not match NUM_REQ");
        end
    endgenerate

    occ_e                 occ_q, occ_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic [IDX_WIDTH-1:0] fifo_mem_q [BUF_SLOTS];

    logic                 space;
    logic                 pick_en;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_any;
    logic                 push;
    logic                 pop;

    // Space depends on registered occupancy only; ready is also held low
    // while reset is asserted so no token is accepted then.
    assign space   = (occ_q != OCC_FULL);
    assign pick_en = space & rst;

    rr_priority_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req_valid_i  (arb_if.req_valid),
        .rr_ptr_i     (rr_ptr_q),
        .enable_i     (pick_en),
        .grant_o      (pick_grant),
        .winner_idx_o (pick_idx),
        .any_grant_o  (pick_any)
    );

    assign arb_if.req_ready   = pick_grant;
    assign arb_if.grant_valid = (occ_q != OCC_EMPTY);
    assign arb_if.grant_idx   = fifo_mem_q[rd_ptr_q];

    assign push = pick_any & |(arb_if.req_valid & pick_grant);
    assign pop  = arb_if.grant_valid & arb_if.grant_ready & rst;

    // Occupancy next state and FIFO pointer advance.
    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case (occ_q)
            OCC_EMPTY: if (push)         occ_d = OCC_ONE;
            OCC_ONE:   if (push && !pop) occ_d = OCC_FULL;
                       else if (!push && pop) occ_d = OCC_EMPTY;
            OCC_FULL:  if (pop)          occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    // Occupancy state and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer slots: cleared on reset so grant_idx reads 0 afterwards.
    genvar gi;
    generate
        for (gi = 0; gi < BUF_SLOTS; gi++) begin : g_slot
            // Slot gi captures the winner when the write pointer targets it.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    fifo_mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    fifo_mem_q[gi] <= pick_idx;
                end
            end
        end
    endgenerate

    // Rotating priority pointer: moves just past each accepted winner.
    generate
        if (NUM_REQ == 1) begin : g_single
            assign rr_ptr_q = '0;
        end else begin : g_multi
            logic [IDX_WIDTH-1:0] rr_ptr_d;

            // Next pointer with explicit wrap for non-power-of-two counts.
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (push) begin
                    rr_ptr_d = (pick_idx == IDX_WIDTH'(NUM_REQ - 1))
                             ? '0 : pick_idx + 1'b1;
                end
            end

            // Pointer register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end
    endgenerate

endmodule
